// File: rtl/flicky_input_cond.sv
// Player-control conditioning: sync + debounce raw requests, latch player bits once
// per frame, and turn queued coin requests into frame-timed active-low pulses.
module flicky_input_cond #(
    parameter int unsigned DEB_CYCLES      = 480000,
    parameter int unsigned DEB_W           = 20,
    parameter int unsigned COIN_FRAMES     = 3,
    parameter int unsigned COIN_GAP_FRAMES = 3
) (
    input  logic       clk48M,
    input  logic       reset,
    input  logic       vblank,
    input  logic [8:0] raw_in,
    output logic [7:0] INP0,
    output logic [7:0] INP1,
    output logic [7:0] INP2,
    output logic [7:0] coin_total,
    output logic [3:0] coin_pending
);

    localparam int unsigned N_IN     = 9;
    localparam int unsigned FCNT_W   = 8;
    localparam int unsigned PEND_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } coin_st_e;

    logic [N_IN-1:0]             raw_s1_q, raw_s2_q;
    logic                        vb_s1_q, vb_s2_q, vb_prev_q;
    logic [N_IN-1:0]             stable_q, stable_d;
    logic [N_IN-1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [7:0]                  lat_q, lat_d;
    logic                        coin_act_q, coin_act_d;
    coin_st_e                    state_q, state_d;
    logic [FCNT_W-1:0]           fcnt_q, fcnt_d;
    logic [7:0]                  total_q, total_d;
    logic [3:0]                  pend_q, pend_d;
    logic                        vb_rise_c, coin_inc_c, coin_dec_c;

    assign vb_rise_c  = vb_s2_q & ~vb_prev_q;
    assign coin_inc_c = stable_d[8] & ~stable_q[8];

    // Per-bit debounce: a new level must persist DEB_CYCLES consecutive synced samples.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (raw_s2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                stable_d[i]  = ~stable_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            raw_s1_q  <= '0;
            raw_s2_q  <= '0;
            vb_s1_q   <= 1'b0;
            vb_s2_q   <= 1'b0;
            vb_prev_q <= 1'b0;
            stable_q  <= '0;
            deb_cnt_q <= '0;
        end else begin
            raw_s1_q  <= raw_in;
            raw_s2_q  <= raw_s1_q;
            vb_s1_q   <= vblank;
            vb_s2_q   <= vb_s1_q;
            vb_prev_q <= vb_s2_q;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Frame latch, coin pulse sequencer and coin queue; everything moves only on vb_rise
    // except the queue, which accepts presses at any time.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        coin_act_d = coin_act_q;
        total_d    = total_q;
        pend_d     = pend_q;
        lat_d      = lat_q;
        coin_dec_c = 1'b0;

        if (vb_rise_c) begin
            lat_d = stable_q[7:0];
            case (state_q)
                ST_IDLE: begin
                    if ((pend_q != 4'd0) || coin_inc_c) begin
                        state_d    = ST_PULSE;
                        fcnt_d     = '0;
                        coin_act_d = 1'b1;
                        total_d    = total_q + 8'd1;
                        coin_dec_c = 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (fcnt_q == FCNT_W'(COIN_FRAMES - 1)) begin
                        state_d    = ST_GAP;
                        fcnt_d     = '0;
                        coin_act_d = 1'b0;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (fcnt_q == FCNT_W'(COIN_GAP_FRAMES - 1)) begin
                        state_d = ST_IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Simultaneous enqueue and issue cancel out; a full queue drops new presses.
        if (coin_inc_c && !coin_dec_c) begin
            if (pend_q != 4'(PEND_MAX)) begin
                pend_d = pend_q + 4'd1;
            end
        end else if (coin_dec_c && !coin_inc_c) begin
            pend_d = pend_q - 4'd1;
        end
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fcnt_q     <= '0;
            coin_act_q <= 1'b0;
            total_q    <= '0;
            pend_q     <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            coin_act_q <= coin_act_d;
            total_q    <= total_d;
            pend_q     <= pend_d;
            lat_q      <= lat_d;
        end
    end

    assign INP0         = ~{lat_q[0], lat_q[1], 3'b000, lat_q[2], 2'b00};
    assign INP1         = ~{lat_q[3], lat_q[4], 3'b000, lat_q[5], 2'b00};
    assign INP2         = ~{2'b00, lat_q[7], lat_q[6], 3'b000, coin_act_q};
    assign coin_total   = total_q;
    assign coin_pending = pend_q;

endmodule

// File: tb/tb_flicky_input_cond.sv
// Bench for flicky_input_cond: directed vector table, coin sequences, and random
// stimulus against a window-based behavioural model.
module tb_flicky_input_cond;

    localparam int unsigned DEB = 4;
    localparam int unsigned CF  = 3;
    localparam int unsigned GF  = 3;

    logic       clk48M = 1'b0;
    logic       reset;
    logic       vblank;
    logic [8:0] raw_in;
    logic [7:0] INP0, INP1, INP2, coin_total;
    logic [3:0] coin_pending;

    int errors = 0;
    int checks = 0;

    flicky_input_cond #(
        .DEB_CYCLES     (DEB),
        .DEB_W          (4),
        .COIN_FRAMES    (CF),
        .COIN_GAP_FRAMES(GF)
    ) dut (
        .clk48M      (clk48M),
        .reset       (reset),
        .vblank      (vblank),
        .raw_in      (raw_in),
        .INP0        (INP0),
        .INP1        (INP1),
        .INP2        (INP2),
        .coin_total  (coin_total),
        .coin_pending(coin_pending)
    );

    always #5 clk48M = ~clk48M;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: history of applied inputs; a bit flips once its last DEB
    // post-synchroniser samples all disagree with the stable value.
    logic [8:0] rh [16];
    logic       vh [4];
    logic [8:0] m_stable;
    logic [7:0] m_lat;
    logic       m_coin;
    int         m_mode, m_left, m_total, m_pend;

    task automatic model_edge(input logic [8:0] r, input logic v, input logic rst);
        logic       vbr, inc, dec, all_diff;
        logic [8:0] st_old;
        if (rst) begin
            for (int i = 0; i < 16; i++) rh[i] = '0;
            for (int i = 0; i < 4; i++) vh[i] = 1'b0;
            m_stable = '0; m_lat = '0; m_coin = 1'b0;
            m_mode = 0; m_left = 0; m_total = 0; m_pend = 0;
            return;
        end
        for (int i = 15; i > 0; i--) rh[i] = rh[i-1];
        rh[0] = r;
        for (int i = 3; i > 0; i--) vh[i] = vh[i-1];
        vh[0] = v;
        vbr    = vh[2] && !vh[3];
        st_old = m_stable;
        for (int b = 0; b < 9; b++) begin
            all_diff = 1'b1;
            for (int d = 2; d <= 1 + int'(DEB); d++)
                if (rh[d][b] == st_old[b]) all_diff = 1'b0;
            if (all_diff) m_stable[b] = ~st_old[b];
        end
        inc = m_stable[8] && !st_old[8];
        dec = 1'b0;
        if (vbr) begin
            m_lat = st_old[7:0];
            if (m_mode == 0) begin
                if (m_pend > 0 || inc) begin
                    dec = 1'b1; m_mode = 1; m_left = CF; m_coin = 1'b1;
                    m_total = (m_total + 1) % 256;
                end
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin m_mode = 2; m_left = GF; m_coin = 1'b0; end
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        if (inc && !dec) begin
            if (m_pend < 15) m_pend++;
        end else if (dec && !inc) begin
            m_pend--;
        end
    endtask

    task automatic check_model();
        chk("rand.INP0", INP0, ~{m_lat[0], m_lat[1], 3'b000, m_lat[2], 2'b00});
        chk("rand.INP1", INP1, ~{m_lat[3], m_lat[4], 3'b000, m_lat[5], 2'b00});
        chk("rand.INP2", INP2, ~{2'b00, m_lat[7], m_lat[6], 3'b000, m_coin});
        chk("rand.total", coin_total, 8'(m_total));
        chk("rand.pending", 8'(coin_pending), 8'(m_pend));
    endtask

    task automatic step(input logic [8:0] r, input logic v, input logic rst);
        raw_in = r; vblank = v; reset = rst;
        @(posedge clk48M);
        model_edge(r, v, rst);
        #1;
    endtask

    // One frame: vblank low 4 cycles then high 4; the rising strobe lands inside it.
    task automatic frame(input logic [8:0] r);
        for (int i = 0; i < 4; i++) step(r, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(r, 1'b1, 1'b0);
    endtask

    task automatic coin_press();
        for (int i = 0; i < 6; i++) step(9'h100, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(9'h000, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [8:0] raw;
        logic       vb;
        logic       rst;
        int         n;
        logic [7:0] e0, e1, e2, et;
        logic [3:0] ep;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [8:0] raw, input logic vb, input logic rst, input int n,
                       input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        vec_t v;
        v.raw = raw; v.vb = vb; v.rst = rst; v.n = n;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.et = 8'h00; v.ep = 4'h0;
        tbl.push_back(v);
    endtask

    logic [8:0] r_cur;
    logic       v_cur;
    int         v_left;
    logic       exp_bit;

    initial begin
        reset = 1'b1; vblank = 1'b0; raw_in = 9'h1FF;

        add(9'h1FF, 1'b0, 1'b1,  3, 8'hFF, 8'hFF, 8'hFF);  // reset with all requests high
        add(9'h1FF, 1'b0, 1'b0,  1, 8'hFF, 8'hFF, 8'hFF);  // one cycle after release
        add(9'h000, 1'b0, 1'b0,  8, 8'hFF, 8'hFF, 8'hFF);
        add(9'h001, 1'b0, 1'b0,  3, 8'hFF, 8'hFF, 8'hFF);  // 3-cycle glitch
        add(9'h000, 1'b1, 1'b0,  4, 8'hFF, 8'hFF, 8'hFF);  // vb_rise latches nothing
        add(9'h000, 1'b0, 1'b0,  4, 8'hFF, 8'hFF, 8'hFF);
        add(9'h001, 1'b0, 1'b0, 10, 8'hFF, 8'hFF, 8'hFF);  // debounced but not latched
        add(9'h001, 1'b1, 1'b0,  2, 8'hFF, 8'hFF, 8'hFF);  // strobe not yet through sync
        add(9'h001, 1'b1, 1'b0,  1, 8'h7F, 8'hFF, 8'hFF);  // cycle after vb_rise
        add(9'h001, 1'b0, 1'b0,  3, 8'h7F, 8'hFF, 8'hFF);
        add(9'h004, 1'b0, 1'b0, 10, 8'h7F, 8'hFF, 8'hFF);  // mid-frame change held off
        add(9'h004, 1'b1, 1'b0,  3, 8'hFB, 8'hFF, 8'hFF);
        add(9'h000, 1'b0, 1'b0, 10, 8'hFB, 8'hFF, 8'hFF);
        add(9'h000, 1'b1, 1'b0,  3, 8'hFF, 8'hFF, 8'hFF);
        add(9'h0F8, 1'b0, 1'b0, 10, 8'hFF, 8'hFF, 8'hFF);
        add(9'h0F8, 1'b1, 1'b0,  3, 8'hFF, 8'h3B, 8'hCF);  // P2 and start bits
        add(9'h000, 1'b0, 1'b0, 10, 8'hFF, 8'h3B, 8'hCF);
        add(9'h000, 1'b1, 1'b0,  3, 8'hFF, 8'hFF, 8'hFF);

        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].n; c++) step(tbl[k].raw, tbl[k].vb, tbl[k].rst);
            chk($sformatf("vec%0d.INP0", k), INP0, tbl[k].e0);
            chk($sformatf("vec%0d.INP1", k), INP1, tbl[k].e1);
            chk($sformatf("vec%0d.INP2", k), INP2, tbl[k].e2);
            chk($sformatf("vec%0d.total", k), coin_total, tbl[k].et);
            chk($sformatf("vec%0d.pending", k), 8'(coin_pending), 8'(tbl[k].ep));
        end

        // Single coin: three frames low, then held high.
        coin_press();
        chk("single.pending_queued", 8'(coin_pending), 8'd1);
        chk("single.idle_INP2", INP2, 8'hFF);
        for (int f = 0; f < 8; f++) begin
            frame(9'h000);
            exp_bit = (f < 3) ? 1'b0 : 1'b1;
            chk($sformatf("single.frame%0d", f), 8'(INP2[0]), 8'(exp_bit));
        end
        chk("single.total", coin_total, 8'd1);
        chk("single.pending", 8'(coin_pending), 8'd0);

        // Burst of four presses inside one frame: four separate 3-low/4-high pulses.
        for (int p = 0; p < 4; p++) coin_press();
        chk("burst.pending", 8'(coin_pending), 8'd4);
        for (int f = 0; f < 30; f++) begin
            frame(9'h000);
            exp_bit = (f < 28 && (f % 7) < 3) ? 1'b0 : 1'b1;
            chk($sformatf("burst.frame%0d", f), 8'(INP2[0]), 8'(exp_bit));
        end
        chk("burst.total", coin_total, 8'd5);
        chk("burst.pending_drained", 8'(coin_pending), 8'd0);

        // Saturation with vblank frozen, then reset in the middle of a pulse.
        for (int p = 0; p < 20; p++) coin_press();
        chk("sat.pending", 8'(coin_pending), 8'd15);
        chk("sat.INP2_frozen", INP2, 8'hFF);
        frame(9'h000);
        chk("sat.pulse_INP2", INP2, 8'hFE);
        chk("sat.pulse_pending", 8'(coin_pending), 8'd14);
        step(9'h000, 1'b1, 1'b1);
        chk("rst_mid.INP2", INP2, 8'hFF);
        chk("rst_mid.pending", 8'(coin_pending), 8'd0);
        chk("rst_mid.total", coin_total, 8'd0);
        for (int f = 0; f < 4; f++) begin
            frame(9'h000);
            chk($sformatf("rst_mid.frame%0d", f), INP2, 8'hFF);
        end
        chk("rst_mid.total_after", coin_total, 8'd0);

        // Random stimulus against the model.
        step(9'h000, 1'b0, 1'b1);
        step(9'h000, 1'b0, 1'b1);
        r_cur = '0; v_cur = 1'b0; v_left = 5;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 9; b++)
                if ($urandom_range(7, 0) == 0) r_cur[b] = ~r_cur[b];
            if (v_left == 0) begin
                v_cur  = ~v_cur;
                v_left = int'($urandom_range(12, 1));
            end
            v_left--;
            step(r_cur, v_cur, 1'b0);
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
